// File: rtl/xs3_pkg.sv
// rtl/xs3_pkg.sv - shared types and constants for the BCD to Excess-3 sequencer
// Purpose: FSM state encoding and the digit-conversion constants.
package xs3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] XS3_OFFSET  = 4'd3;
  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] XS3_INVALID = 4'h0;

endpackage

// File: rtl/bcd_digit_xs3.sv
// rtl/bcd_digit_xs3.sv - combinational single-digit BCD to Excess-3 converter
// Purpose: converts one BCD digit; non-BCD codes give XS3_INVALID and a flag.
// Ports:
//   i_digit   in  4  BCD digit
//   o_xs3     out 4  Excess-3 digit (d+3, or XS3_INVALID when d > 9)
//   o_invalid out 1  set when i_digit is 10..15
module bcd_digit_xs3
  import xs3_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_xs3,
  output logic       o_invalid
);

  logic w_invalid;

  assign w_invalid = (i_digit > BCD_MAX);
  // 9 + 3 = 4'hC fits in the nibble, so no carry handling is needed.
  assign o_xs3     = w_invalid ? XS3_INVALID : (i_digit + XS3_OFFSET);
  assign o_invalid = w_invalid;

endmodule

// File: rtl/bcd_xs3_seq_ctrl.sv
// rtl/bcd_xs3_seq_ctrl.sv - digit-serial BCD word to Excess-3 word controller
// Purpose: accepts a packed BCD word, converts one digit per clock (LSD first)
// through a single shared converter, then presents the Excess-3 word.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready/in_bcd       producer handshake and packed BCD word
//   out_valid/out_ready/out_xs3    consumer handshake and packed Excess-3 word
//   out_err_mask, out_err          per-digit non-BCD flags and their OR
//   busy                           high while converting or holding a result
module bcd_xs3_seq_ctrl
  import xs3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_xs3,
  output logic [DIGITS-1:0]     out_err_mask,
  output logic                  out_err,
  output logic                  busy
);

  localparam int CW = $clog2(DIGITS + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [4*DIGITS-1:0] r_shift;
  logic [CW-1:0]       r_cnt;
  logic [4*DIGITS-1:0] r_xs3;
  logic [DIGITS-1:0]   r_mask;
  logic [3:0]          w_dig_xs3;
  logic                w_dig_bad;
  logic                w_last;
  logic                w_accept;
  logic                w_deliver;

  bcd_digit_xs3 u_digit (
    .i_digit   (r_shift[3:0]),
    .o_xs3     (w_dig_xs3),
    .o_invalid (w_dig_bad)
  );

  assign w_last    = (r_cnt == CW'(DIGITS - 1));
  assign w_accept  = in_valid && in_ready;
  assign w_deliver = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_state_nxt = CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (w_deliver) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_xs3   <= '0;
      r_mask  <= '0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_shift <= in_bcd;
        r_cnt   <= '0;
        r_xs3   <= '0;
        r_mask  <= '0;
      end
    end else if (r_state == CONV) begin
      r_shift <= r_shift >> 4;
      r_cnt   <= r_cnt + 1'b1;
      // Decoded slot write keeps every index statically in range.
      for (int k = 0; k < DIGITS; k++) begin
        if (r_cnt == CW'(k)) begin
          r_xs3[4*k +: 4] <= w_dig_xs3;
          r_mask[k]       <= w_dig_bad;
        end
      end
    end
  end

  assign out_xs3      = r_xs3;
  assign out_err_mask = r_mask;
  assign out_err      = |r_mask;

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// tb/tb_bcd_xs3_seq_ctrl.sv - directed self-checking bench for bcd_xs3_seq_ctrl
module tb_bcd_xs3_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_xs3;
  logic [3:0]  out_err_mask;
  logic        out_err;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  bcd_xs3_seq_ctrl #(.DIGITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bcd       (in_bcd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_xs3      (out_xs3),
    .out_err_mask (out_err_mask),
    .out_err      (out_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One word with out_ready held high: accept, 4 conversion edges, 1-cycle result.
  task automatic run_word(input string tag, input logic [15:0] bcd,
                          input logic [15:0] exp_xs3, input logic [3:0] exp_mask);
    out_ready = 1'b1;
    in_bcd    = bcd;
    in_valid  = 1'b1;
    chk({tag, "_in_ready_idle"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk({tag, "_conv_no_valid"}, out_valid, 1'b0);
      chk({tag, "_conv_busy"}, busy, 1'b1);
      tick();
    end
    chk({tag, "_conv_no_valid"}, out_valid, 1'b0);
    tick();
    chk({tag, "_out_valid"}, out_valid, 1'b1);
    chk({tag, "_in_ready_done"}, in_ready, 1'b0);
    chk({tag, "_xs3"}, out_xs3, exp_xs3);
    chk({tag, "_mask"}, out_err_mask, exp_mask);
    chk({tag, "_err"}, out_err, |exp_mask);
    tick();
    chk({tag, "_valid_one_cycle"}, out_valid, 1'b0);
    chk({tag, "_in_ready_back"}, in_ready, 1'b1);
  endtask

  logic [15:0] s_in  [4];
  logic [15:0] s_exp [4];
  int          n_acc;
  int          n_out;
  bit          acc_now;
  bit          out_now;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bcd    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_xs3", out_xs3, 16'h0000);
    chk("rst_mask", out_err_mask, 4'b0000);
    chk("rst_err", out_err, 1'b0);
    chk("rst_busy", busy, 1'b0);

    run_word("basic", 16'h1234, 16'h4567, 4'b0000);
    run_word("zeros", 16'h0000, 16'h3333, 4'b0000);
    run_word("nines", 16'h9999, 16'hCCCC, 4'b0000);
    run_word("bad",   16'h9A05, 16'hC038, 4'b0100);

    // Backpressure in DONE, with a competing word offered meanwhile.
    out_ready = 1'b0;
    in_bcd    = 16'h5678;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("bp_valid", out_valid, 1'b1);
    in_bcd   = 16'h1111;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_xs3", out_xs3, 16'h89AB);
      chk("bp_hold_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_in_ready", in_ready, 1'b1);
    chk("bp_result_kept", out_xs3, 16'h89AB);

    // Reset asserted on the second CONV edge.
    in_bcd   = 16'h8765;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_xs3", out_xs3, 16'h0000);
    chk("mid_rst_mask", out_err_mask, 4'b0000);
    chk("mid_rst_busy", busy, 1'b0);
    run_word("after_rst", 16'h0421, 16'h3754, 4'b0000);

    // Streaming: in_valid held high across four words.
    s_in[0] = 16'h0123; s_exp[0] = 16'h3456;
    s_in[1] = 16'h4567; s_exp[1] = 16'h789A;
    s_in[2] = 16'h8901; s_exp[2] = 16'hBC34;
    s_in[3] = 16'hF999; s_exp[3] = 16'h0CCC;
    n_acc     = 0;
    n_out     = 0;
    out_ready = 1'b1;
    in_bcd    = s_in[0];
    in_valid  = 1'b1;
    for (int c = 0; c < 60 && n_out < 4; c++) begin
      acc_now = in_valid && in_ready;
      out_now = out_valid && out_ready;
      chk("stream_no_overlap", in_ready && out_valid, 1'b0);
      if (out_now) begin
        chk("stream_xs3", out_xs3, s_exp[n_out]);
        chk("stream_err", out_err, (n_out == 3));
        n_out++;
      end
      tick();
      if (acc_now) begin
        n_acc++;
        if (n_acc < 4) in_bcd = s_in[n_acc];
        else           in_valid = 1'b0;
      end
    end
    chk("stream_accepted", n_acc, 4);
    chk("stream_delivered", n_out, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
